// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate truth-table probe: gate codes, reference tables,
// FSM encoding.
package gate_pkg;

  localparam logic [2:0] GATE_UNKNOWN = 3'd0;
  localparam logic [2:0] GATE_AND     = 3'd1;
  localparam logic [2:0] GATE_OR      = 3'd2;
  localparam logic [2:0] GATE_NAND    = 3'd3;
  localparam logic [2:0] GATE_NOR     = 3'd4;
  localparam logic [2:0] GATE_XOR     = 3'd5;
  localparam logic [2:0] GATE_XNOR    = 3'd6;

  // Bit i of a table holds y for {a,b} == i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StDecode,
    StDone
  } state_e;

endpackage

// File: rtl/gate_tt_decode.sv
// Combinational map from a 4-bit truth table to a gate identity.
module gate_tt_decode
  import gate_pkg::*;
(
  input  logic [3:0] tt_i,
  output logic [2:0] gate_id_o,
  output logic       valid_o
);

  always_comb begin
    gate_id_o = GATE_UNKNOWN;
    case (tt_i)
      TT_AND:  gate_id_o = GATE_AND;
      TT_OR:   gate_id_o = GATE_OR;
      TT_NAND: gate_id_o = GATE_NAND;
      TT_NOR:  gate_id_o = GATE_NOR;
      TT_XOR:  gate_id_o = GATE_XOR;
      TT_XNOR: gate_id_o = GATE_XNOR;
      default: gate_id_o = GATE_UNKNOWN;
    endcase
    valid_o = (gate_id_o != GATE_UNKNOWN);
  end

endmodule

// File: rtl/gate_tt_probe.sv
// Sweeps all four input vectors through a 2-input gate, records its truth table and
// identifies the gate.
module gate_tt_probe
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SETTLE_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic [3:0] truth_table,
  output logic [2:0] gate_id,
  output logic       valid_gate
);

  localparam logic [SETTLE_W-1:0] SettleLast = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                a_q, a_d, b_q, b_d;
  logic [3:0]          tt_q, tt_d;
  logic [2:0]          id_q, id_d;
  logic                valid_q, valid_d;

  logic [2:0] dec_id;
  logic       dec_valid;

  gate_tt_decode u_decode (
    .tt_i      (tt_q),
    .gate_id_o (dec_id),
    .valid_o   (dec_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    tt_d    = tt_q;
    id_d    = id_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = StSettle;
          cnt_d   = '0;
          idx_d   = 2'd0;
          tt_d    = 4'b0000;
          id_d    = GATE_UNKNOWN;
          valid_d = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        tt_d[idx_q] = y_in;
        if (idx_q == 2'd3) begin
          state_d = StDecode;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          // Next vector is registered together with the index so it is stable for all of SETTLE.
          idx_d        = idx_q + 2'd1;
          {a_d, b_d}   = idx_q + 2'd1;
          state_d      = StSettle;
        end
      end
      StDecode: begin
        id_d    = dec_id;
        valid_d = dec_valid;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      tt_q    <= 4'b0000;
      id_q    <= GATE_UNKNOWN;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tt_q    <= tt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign a_out       = a_q;
  assign b_out       = b_q;
  assign truth_table = tt_q;
  assign gate_id     = id_q;
  assign valid_gate  = valid_q;

endmodule

// File: tb/tb_gate_tt_probe.sv
// Directed bench for gate_tt_probe: OR/AND/zero gates on a default instance, XNOR on a
// SETTLE_CYCLES=4 instance.
module tb_gate_tt_probe;

  logic       clk = 1'b0;
  logic       rst_n, start, start4;
  logic       busy, done, a_out, b_out, y_in;
  logic [3:0] truth_table;
  logic [2:0] gate_id;
  logic       valid_gate;
  logic       busy4, done4, a4, b4, y4;
  logic [3:0] tt4;
  logic [2:0] id4;
  logic       valid4;

  int mode;  // 0 OR, 1 tied-low, 2 AND
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int done_n = 0;
  int done_t [16];
  logic [2:0] done_id [16];
  int done4_n = 0;
  int done4_t = 0;
  int e0, d0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (mode)
      0:       y_in = a_out | b_out;
      1:       y_in = 1'b0;
      default: y_in = a_out & b_out;
    endcase
  end
  assign y4 = ~(a4 ^ b4);

  gate_tt_probe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .a_out       (a_out),
    .b_out       (b_out),
    .y_in        (y_in),
    .truth_table (truth_table),
    .gate_id     (gate_id),
    .valid_gate  (valid_gate)
  );

  gate_tt_probe #(.SETTLE_CYCLES(4), .SETTLE_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start4),
    .busy        (busy4),
    .done        (done4),
    .a_out       (a4),
    .b_out       (b4),
    .y_in        (y4),
    .truth_table (tt4),
    .gate_id     (id4),
    .valid_gate  (valid4)
  );

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_n < 16) begin
        done_t[done_n]  = cyc;
        done_id[done_n] = gate_id;
      end
      done_n++;
    end
    if (done4 === 1'b1) begin
      done4_t = cyc;
      done4_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(output int t0);
    step();
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic wait_t(input int t0, input int t);
    while (cyc - t0 < t) step();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start4 = 1'b0;
    mode   = 0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ab", {a_out, b_out}, 0);
    check("reset_tt", truth_table, 0);
    check("reset_id_valid", {gate_id, valid_gate}, 0);
    rst_n = 1'b1;

    // OR gate, default settle
    d0 = done_n;
    start_run(e0);
    check("or_busy_after_start", busy, 1);
    wait_done(40);
    check("or_done_edge", done_t[d0] - e0, 13);
    check("or_tt", truth_table, 4'b1110);
    check("or_id", gate_id, 2);
    check("or_valid", valid_gate, 1);
    step();
    check("or_done_one_cycle", done, 0);
    check("or_busy_low", busy, 0);
    check("or_tt_hold", truth_table, 4'b1110);
    check("or_done_count", done_n - d0, 1);

    // XNOR with four settle cycles
    step();
    start4 = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start4 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) step();
      check("xnor_vector", {a4, b4}, (cyc - e0) / 5);
    end
    begin
      int k;
      k = 0;
      while (done4 !== 1'b1 && k < 40) begin
        step();
        k++;
      end
    end
    check("xnor_done_seen", done4, 1);
    check("xnor_done_edge", done4_t - e0, 21);
    check("xnor_tt", tt4, 4'b1001);
    check("xnor_id", id4, 6);
    check("xnor_valid", valid4, 1);

    // y tied low
    mode = 1;
    d0 = done_n;
    start_run(e0);
    check("zero_clears_tt_on_start", truth_table, 0);
    wait_done(40);
    check("zero_tt", truth_table, 0);
    check("zero_id", gate_id, 0);
    check("zero_valid", valid_gate, 0);
    check("zero_done_count", done_n - d0, 1);

    // start re-pulsed mid-run and during DONE
    mode = 0;
    d0 = done_n;
    start_run(e0);
    wait_t(e0, 2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignore_busy", busy, 1);
    wait_done(40);
    check("ignore_done_edge", done_t[d0] - e0, 13);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    step();
    check("ignore_busy_after_done", busy, 0);
    step();
    check("ignore_not_queued", busy, 0);
    check("ignore_done_count", done_n - d0, 1);

    // reset mid-run
    start_run(e0);
    wait_t(e0, 5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_tt", truth_table, 0);
    check("midrst_ab", {a_out, b_out}, 0);
    check("midrst_id_valid", {gate_id, valid_gate}, 0);
    d0 = done_n;
    repeat (20) step();
    check("midrst_no_done", done_n - d0, 0);
    start_run(e0);
    wait_done(40);
    check("midrst_fresh_edge", done_t[d0] - e0, 13);
    check("midrst_fresh_tt", truth_table, 4'b1110);
    check("midrst_fresh_id", gate_id, 2);

    // start held high, AND gate: runs repeat every 15 edges
    mode = 2;
    step();
    d0 = done_n;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    repeat (39) @(posedge clk);
    #1;
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (done_n - d0 < 3 && k < 40) begin
        step();
        k++;
      end
    end
    repeat (20) step();
    check("b2b_done_count", done_n - d0, 3);
    check("b2b_first_edge", done_t[d0] - e0, 13);
    check("b2b_gap1", done_t[d0+1] - done_t[d0], 15);
    check("b2b_gap2", done_t[d0+2] - done_t[d0+1], 15);
    check("b2b_id0", done_id[d0], 1);
    check("b2b_id1", done_id[d0+1], 1);
    check("b2b_id2", done_id[d0+2], 1);
    check("b2b_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
